// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fft_pkg
// Brief    : Shared constants, sample/state types and twiddle helper for the
//            radix-2 FFT butterfly sequencer.
// Revision : 1.0
// ============================================================================
package fft_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 15;
    localparam int ANGLE_BITS = FRAC_BITS + 1;

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] im;
        logic signed [DATA_WIDTH-1:0] re;
    } cplx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fsm_state_t;

    // Unwrapped angle j << (angle_bits-1-s); callers truncate to their width,
    // which gives the modulo-2^angle_bits wrap.
    function automatic logic [31:0] angle_for(input int angle_bits, input int s, input int j);
        angle_for = 32'(j) << (angle_bits - 1 - s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : fft_addr_gen
// Brief    : Combinational (stage, butterfly index) -> operand addresses and
//            twiddle angle for an in-place radix-2 DIT FFT.
// Revision : 1.0
// ============================================================================
module fft_addr_gen #(
    parameter int LOG2N      = 4,
    parameter int ANGLE_BITS = 16,
    parameter int SW         = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
    input  logic [SW-1:0]         stage,
    input  logic [LOG2N-2:0]      k,
    output logic [LOG2N-1:0]      addr_a,
    output logic [LOG2N-1:0]      addr_b,
    output logic [ANGLE_BITS-1:0] angle
);
    import fft_pkg::*;

    logic [LOG2N-1:0] w_k_ext;
    logic [LOG2N-1:0] w_h;
    logic [LOG2N-1:0] w_j;
    logic [LOG2N-1:0] w_g;

    always_comb begin
        w_k_ext = {1'b0, k};
        w_h     = LOG2N'(1) << stage;
        w_j     = w_k_ext & (w_h - 1'b1);
        w_g     = w_k_ext >> stage;
        // Group base is g*2h; the b operand sits h above its a partner.
        addr_a  = ((w_g << stage) << 1) | w_j;
        addr_b  = addr_a + w_h;
        angle   = ANGLE_BITS'(angle_for(ANGLE_BITS, int'(stage), int'(w_j)));
    end

endmodule
`default_nettype wire

// File: rtl/fft_bfly_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_bfly_sequencer
// Brief    : In-place radix-2 DIT FFT sequencer: reads operand pairs, feeds an
//            external fixed-latency butterfly and writes results back.
//            Optional macro FFT_SEQ_INVERSE_EN adds inverse_i (conjugate twiddle).
// Revision : 1.0
// ============================================================================
module fft_bfly_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 15,
    parameter int LOG2N      = 4,
    parameter int BFLY_LAT   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst,
    input  logic                    start_i,
`ifdef FFT_SEQ_INVERSE_EN
    input  logic                    inverse_i,
`endif
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    rd_en_o,
    output logic [LOG2N-1:0]        rd_addr_a_o,
    output logic [LOG2N-1:0]        rd_addr_b_o,
    input  logic [2*DATA_WIDTH-1:0] rd_data_a_i,
    input  logic [2*DATA_WIDTH-1:0] rd_data_b_i,
    output logic [FRAC_BITS:0]      bfly_twid_o,
    output logic [2*DATA_WIDTH-1:0] bfly_a_o,
    output logic [2*DATA_WIDTH-1:0] bfly_b_o,
    input  logic [2*DATA_WIDTH-1:0] bfly_a_i,
    input  logic [2*DATA_WIDTH-1:0] bfly_b_i,
    output logic                    wr_en_o,
    output logic [LOG2N-1:0]        wr_addr_a_o,
    output logic [LOG2N-1:0]        wr_addr_b_o,
    output logic [2*DATA_WIDTH-1:0] wr_data_a_o,
    output logic [2*DATA_WIDTH-1:0] wr_data_b_o
);
    import fft_pkg::*;

    localparam int ABITS      = FRAC_BITS + 1;
    localparam int SW         = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int KW         = LOG2N - 1;
    localparam int PIPE_DEPTH = 1 + BFLY_LAT;
    localparam int DCW        = $clog2(PIPE_DEPTH + 1);

    typedef struct packed {
        logic             vld;
        logic [LOG2N-1:0] addr_a;
        logic [LOG2N-1:0] addr_b;
    } wr_tag_t;

    fsm_state_t       r_state, w_state_nxt;
    logic [SW-1:0]    r_stage, w_stage_nxt;
    logic [KW-1:0]    r_k, w_k_nxt;
    logic [DCW-1:0]   r_drain, w_drain_nxt;
    logic             w_busy, w_done, w_rd_en;

    logic [LOG2N-1:0] w_gen_addr_a, w_gen_addr_b;
    logic [ABITS-1:0] w_gen_angle, w_angle_issued;
    logic [ABITS-1:0] r_twid;
    logic             r_rd_vld;
    logic             r_inverse;
    wr_tag_t          w_tag;
    wr_tag_t          r_wr_pipe [PIPE_DEPTH];

    fft_addr_gen #(
        .LOG2N      (LOG2N),
        .ANGLE_BITS (ABITS),
        .SW         (SW)
    ) u_addr_gen (
        .stage  (r_stage),
        .k      (r_k),
        .addr_a (w_gen_addr_a),
        .addr_b (w_gen_addr_b),
        .angle  (w_gen_angle)
    );

    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_state <= IDLE;
            r_stage <= '0;
            r_k     <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
            r_k     <= w_k_nxt;
            r_drain <= w_drain_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        w_k_nxt     = r_k;
        w_drain_nxt = r_drain;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_rd_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt = ISSUE;
                    w_stage_nxt = '0;
                    w_k_nxt     = '0;
                end
            end
            ISSUE: begin
                w_busy  = 1'b1;
                w_rd_en = 1'b1;
                if (r_k == KW'((1 << (LOG2N - 1)) - 1)) begin
                    w_state_nxt = DRAIN;
                    w_k_nxt     = '0;
                    w_drain_nxt = '0;
                end else begin
                    w_k_nxt = r_k + 1'b1;
                end
            end
            DRAIN: begin
                w_busy = 1'b1;
                // The last write of the stage is on the wire in the final drain cycle.
                if (r_drain == DCW'(PIPE_DEPTH - 1)) begin
                    w_drain_nxt = '0;
                    if (r_stage == SW'(LOG2N - 1)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = ISSUE;
                        w_stage_nxt = r_stage + 1'b1;
                        w_k_nxt     = '0;
                    end
                end else begin
                    w_drain_nxt = r_drain + 1'b1;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef FFT_SEQ_INVERSE_EN
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_inverse <= 1'b0;
        end else if (r_state == IDLE && start_i) begin
            r_inverse <= inverse_i;
        end
    end
`else
    assign r_inverse = 1'b0;
`endif

    assign w_angle_issued = r_inverse ? ('0 - w_gen_angle) : w_gen_angle;

    always_comb begin
        w_tag.vld    = w_rd_en;
        w_tag.addr_a = w_rd_en ? w_gen_addr_a : '0;
        w_tag.addr_b = w_rd_en ? w_gen_addr_b : '0;
    end

    // Twiddle is delayed one cycle to line up with the memory read data.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            r_twid   <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_twid   <= w_rd_en ? w_angle_issued : '0;
            r_rd_vld <= w_rd_en;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_wr_pipe[i] <= '0;
            end
        end else begin
            r_wr_pipe[0] <= w_tag;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_wr_pipe[i] <= r_wr_pipe[i-1];
            end
        end
    end

    assign busy_o      = w_busy;
    assign done_o      = w_done;
    assign rd_en_o     = w_rd_en;
    assign rd_addr_a_o = w_tag.addr_a;
    assign rd_addr_b_o = w_tag.addr_b;
    assign bfly_twid_o = r_twid;
    assign bfly_a_o    = r_rd_vld ? rd_data_a_i : '0;
    assign bfly_b_o    = r_rd_vld ? rd_data_b_i : '0;
    assign wr_en_o     = r_wr_pipe[PIPE_DEPTH-1].vld;
    assign wr_addr_a_o = r_wr_pipe[PIPE_DEPTH-1].addr_a;
    assign wr_addr_b_o = r_wr_pipe[PIPE_DEPTH-1].addr_b;
    assign wr_data_a_o = wr_en_o ? bfly_a_i : '0;
    assign wr_data_b_o = wr_en_o ? bfly_b_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_fft_bfly_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fft_bfly_sequencer
// Brief    : Self-checking bench: memory + ideal 8-cycle butterfly around the
//            sequencer, cycle-exact trace checks and an in-place FFT model.
// Revision : 1.0
// ============================================================================
module tb_fft_bfly_sequencer;

    localparam int N      = 16;
    localparam int HALF   = N / 2;
    localparam int LAT    = 8;
    localparam int STAGES = 4;
    localparam int PERIOD = HALF + 1 + LAT;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
`ifdef FFT_SEQ_INVERSE_EN
    logic        inverse_i;
`endif
    logic        busy_o, done_o, rd_en_o, wr_en_o;
    logic [3:0]  rd_addr_a_o, rd_addr_b_o, wr_addr_a_o, wr_addr_b_o;
    logic [31:0] rd_a, rd_b;
    logic [15:0] bfly_twid_o;
    logic [31:0] bfly_a_o, bfly_b_o, bfly_a_i, bfly_b_i;
    logic [31:0] wr_data_a_o, wr_data_b_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem     [N];
    logic [31:0] stim    [N];
    logic [31:0] ref_mem [N];
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic [63:0] bp [LAT];

    always #5 clk = ~clk;

    fft_bfly_sequencer #(
        .DATA_WIDTH (16),
        .FRAC_BITS  (15),
        .LOG2N      (4),
        .BFLY_LAT   (LAT)
    ) dut (
        .clk_i       (clk),
        .rst         (rst),
        .start_i     (start_i),
`ifdef FFT_SEQ_INVERSE_EN
        .inverse_i   (inverse_i),
`endif
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rd_en_o     (rd_en_o),
        .rd_addr_a_o (rd_addr_a_o),
        .rd_addr_b_o (rd_addr_b_o),
        .rd_data_a_i (rd_a),
        .rd_data_b_i (rd_b),
        .bfly_twid_o (bfly_twid_o),
        .bfly_a_o    (bfly_a_o),
        .bfly_b_o    (bfly_b_o),
        .bfly_a_i    (bfly_a_i),
        .bfly_b_i    (bfly_b_i),
        .wr_en_o     (wr_en_o),
        .wr_addr_a_o (wr_addr_a_o),
        .wr_addr_b_o (wr_addr_b_o),
        .wr_data_a_o (wr_data_a_o),
        .wr_data_b_o (wr_data_b_o)
    );

    // Ideal butterfly: {b_out, a_out} = {a - W*b, a + W*b}, W = exp(i*2*pi*ang/2^16).
    function automatic logic [63:0] bfly_f(input logic [31:0] a, input logic [31:0] b,
                                           input logic [15:0] ang);
        real th, c, s, br, bi, wr, wi;
        int  ar, ai, tr, ti, xr, xi, yr, yi;
        th = 2.0 * 3.14159265358979 * real'(ang) / 65536.0;
        c  = $cos(th);
        s  = $sin(th);
        br = real'($signed(b[15:0]));
        bi = real'($signed(b[31:16]));
        wr = br * c - bi * s;
        wi = br * s + bi * c;
        tr = int'(wr);
        ti = int'(wi);
        ar = int'($signed(a[15:0]));
        ai = int'($signed(a[31:16]));
        xr = ar + tr; xi = ai + ti;
        yr = ar - tr; yi = ai - ti;
        return {yi[15:0], yr[15:0], xi[15:0], xr[15:0]};
    endfunction

    always @(posedge clk) begin
        bp[0] <= bfly_f(bfly_a_o, bfly_b_o, bfly_twid_o);
        for (int i = 1; i < LAT; i++) bp[i] <= bp[i-1];
    end
    assign bfly_a_i = bp[LAT-1][31:0];
    assign bfly_b_i = bp[LAT-1][63:32];

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        if (wr_en_o) begin
            mem[wr_addr_a_o] <= wr_data_a_o;
            mem[wr_addr_b_o] <= wr_data_b_o;
        end
        if (rd_en_o) begin
            rd_a <= mem[rd_addr_a_o];
            rd_b <= mem[rd_addr_b_o];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pair of butterfly k in stage s: a = (k / h) * 2h + k % h, b = a + h.
    function automatic int addr_of(input int s, input int k, input bit upper);
        int h;
        h = 1 << s;
        return (k / h) * 2 * h + (k % h) + (upper ? h : 0);
    endfunction

    // Twiddle is the fraction (k % h)/(2h) of a full turn, negated for inverse.
    function automatic int angle_of(input int s, input int k, input bit inv);
        int h, a;
        h = 1 << s;
        a = ((k % h) * 65536 / (2 * h)) % 65536;
        return inv ? (65536 - a) % 65536 : a;
    endfunction

    task automatic model_fft(input bit inv);
        logic [63:0] r;
        int a, b;
        for (int s = 0; s < STAGES; s++) begin
            for (int k = 0; k < HALF; k++) begin
                a = addr_of(s, k, 1'b0);
                b = addr_of(s, k, 1'b1);
                r = bfly_f(ref_mem[a], ref_mem[b], 16'(angle_of(s, k, inv)));
                ref_mem[a] = r[31:0];
                ref_mem[b] = r[63:32];
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mem();
        for (int i = 0; i < N; i++) begin
            ld_en   = 1'b1;
            ld_addr = 4'(i);
            ld_data = stim[i];
            step();
            chk("idle_rd_en", rd_en_o, 0);
            chk("idle_wr_en", wr_en_o, 0);
        end
        ld_en = 1'b0;
        for (int i = 0; i < N; i++) ref_mem[i] = stim[i];
    endtask

    function automatic logic [31:0] rnd_sample();
        int r, i;
        r = int'($urandom_range(2000)) - 1000;
        i = int'($urandom_range(2000)) - 1000;
        return {i[15:0], r[15:0]};
    endfunction

    function automatic logic [63:0] ctl_vec();
        return {28'd0, busy_o, done_o, rd_en_o, wr_en_o, rd_addr_a_o, rd_addr_b_o,
                wr_addr_a_o, wr_addr_b_o, bfly_twid_o};
    endfunction

    // Caller sits just after an edge; that cycle is cycle 0 (start asserted).
    task automatic run_fft(input int glitch1, input int glitch2, input bit inv);
        bit exp_rd, exp_wr, prev_rd;
        int p, o, prev_ang;
        start_i = 1'b1;
`ifdef FFT_SEQ_INVERSE_EN
        inverse_i = inv;
`endif
        chk("c0_busy", busy_o, 0);
        prev_rd  = 1'b0;
        prev_ang = 0;
        for (int c = 1; c <= STAGES * PERIOD + 2; c++) begin
            step();
            start_i = (c == glitch1 || c == glitch2);
`ifdef FFT_SEQ_INVERSE_EN
            inverse_i = ~inv;
`endif
            p = (c - 1) / PERIOD;
            o = (c - 1) % PERIOD;
            exp_rd = (c <= STAGES * PERIOD) && (o < HALF);
            exp_wr = (c <= STAGES * PERIOD) && (o > LAT);
            chk($sformatf("rd_en@%0d", c), rd_en_o, exp_rd);
            chk($sformatf("wr_en@%0d", c), wr_en_o, exp_wr);
            chk($sformatf("busy@%0d", c), busy_o, c <= STAGES * PERIOD);
            chk($sformatf("done@%0d", c), done_o, c == STAGES * PERIOD + 1);
            if (exp_rd) begin
                chk($sformatf("rd_addr_a@%0d", c), rd_addr_a_o, addr_of(p, o, 1'b0));
                chk($sformatf("rd_addr_b@%0d", c), rd_addr_b_o, addr_of(p, o, 1'b1));
            end
            if (exp_wr) begin
                chk($sformatf("wr_addr_a@%0d", c), wr_addr_a_o, addr_of(p, o - LAT - 1, 1'b0));
                chk($sformatf("wr_addr_b@%0d", c), wr_addr_b_o, addr_of(p, o - LAT - 1, 1'b1));
            end
            if (prev_rd) chk($sformatf("twid@%0d", c), bfly_twid_o, prev_ang);
            if (c == PERIOD + 4) begin
                chk("s1k3_addr", {rd_addr_a_o, rd_addr_b_o}, {4'd5, 4'd7});
            end
            if (c == PERIOD + 5) begin
                chk("s1k3_twid", bfly_twid_o, inv ? 16'hC000 : 16'h4000);
            end
            prev_rd  = exp_rd;
            prev_ang = exp_rd ? angle_of(p, o, inv) : 0;
        end
        start_i = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < N; i++) chk($sformatf("%s[%0d]", tag, i), mem[i], ref_mem[i]);
    endtask

    initial begin
        rst     = 1'b1;
        start_i = 1'b0;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
`ifdef FFT_SEQ_INVERSE_EN
        inverse_i = 1'b0;
`endif
        repeat (3) step();
        chk("reset_ctl", ctl_vec(), 0);
        chk("reset_bfly", {bfly_a_o, bfly_b_o}, 0);
        chk("reset_wdata", {wr_data_a_o, wr_data_b_o}, 0);
        rst = 1'b0;

        // Impulse: every bin equals the impulse amplitude.
        for (int i = 0; i < N; i++) stim[i] = (i == 0) ? 32'h0000_4000 : 32'h0;
        load_mem();
        run_fft(30, -1, 1'b0);
        for (int i = 0; i < N; i++) chk($sformatf("impulse[%0d]", i), mem[i], 32'h0000_4000);

        // Random data, start re-asserted mid-run and in the done cycle.
        for (int i = 0; i < N; i++) stim[i] = rnd_sample();
        load_mem();
        model_fft(1'b0);
        run_fft(30, STAGES * PERIOD + 1, 1'b0);
        check_mem("rand");

        // Reset in cycle 30 aborts the transform.
        for (int i = 0; i < N; i++) stim[i] = rnd_sample();
        load_mem();
        start_i = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            start_i = 1'b0;
            rst     = (c == 30);
        end
        step();
        rst = 1'b0;
        chk("abort_ctl", ctl_vec(), 0);
        chk("abort_bfly", {bfly_a_o, bfly_b_o}, 0);
        chk("abort_wdata", {wr_data_a_o, wr_data_b_o}, 0);
        for (int c = 0; c < 20; c++) begin
            step();
            chk("abort_wr_en", wr_en_o, 0);
            chk("abort_busy", busy_o, 0);
        end

        for (int i = 0; i < N; i++) stim[i] = rnd_sample();
        load_mem();
        model_fft(1'b0);
        run_fft(-1, -1, 1'b0);
        check_mem("after_abort");

`ifdef FFT_SEQ_INVERSE_EN
        for (int i = 0; i < N; i++) stim[i] = rnd_sample();
        load_mem();
        model_fft(1'b1);
        run_fft(-1, -1, 1'b1);
        check_mem("inverse");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_bfly_sequencer.md
Name: fft_bfly_sequencer

Overview:
Sequencer for an in-place radix-2 decimation-in-time FFT built around `butterfly_cordic`.
- Reads operand pairs from dual-port sample memory, then drives the butterfly with a, b and the twiddle angle.
- Collects a_o/b_o after the fixed butterfly latency and writes them back to the same addresses.
- Steps through all LOG2N stages per start request.
- Input data must already be in bit-reversed order in memory.

Parameters:
- DATA_WIDTH, 16, width of each real/imag component (Q1.FRAC_BITS signed).
- FRAC_BITS, 15, fractional bits; angle width ANGLE_BITS = FRAC_BITS+1 (0..2^ANGLE_BITS-1 maps to 0..2π).
- LOG2N, 4, log2 of FFT size N (N=16).
- BFLY_LAT, 8, butterfly input-to-output latency in clocks; must match the instantiated butterfly.

Ports:
- clk_i  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  start-FFT request.
- busy_o  out  1  transform in progress.
- done_o  out  1  one-cycle completion pulse.
- rd_en_o  out  1  memory read strobe, both ports.
- rd_addr_a_o, rd_addr_b_o  out  LOG2N each  read addresses.
- rd_data_a_i, rd_data_b_i  in  2*DATA_WIDTH each  read data {im,re}, valid 1 cycle after rd_en_o.
- bfly_twid_o  out  ANGLE_BITS  twiddle angle to butterfly.
- bfly_a_o, bfly_b_o  out  2*DATA_WIDTH each  butterfly operands ([0]=re, [1]=im).
- bfly_a_i, bfly_b_i  in  2*DATA_WIDTH each  butterfly results.
- wr_en_o  out  1  memory write strobe, both ports.
- wr_addr_a_o, wr_addr_b_o  out  LOG2N each  write addresses.
- wr_data_a_o, wr_data_b_o  out  2*DATA_WIDTH each  write data.

Behaviour:
- Reset: FSM→IDLE, all counters 0, pipeline valid bits cleared. busy_o, done_o, rd_en_o and wr_en_o are 0. All address, data and twiddle outputs are 0.
- Reset mid-operation aborts immediately; no further writes occur.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: when start_i=1, go to ISSUE with stage s=0, butterfly k=0.
- ISSUE: assert rd_en_o every cycle for k = 0..N/2-1.
  - h = 2^s, j = k mod h, g = k>>s.
  - addr_a = g*2h + j; addr_b = addr_a + h.
  - angle = j << (ANGLE_BITS-1-s), computed modulo 2^ANGLE_BITS.
  - After k = N/2-1, go to DRAIN.
- Operand path: the angle is registered 1 cycle so that bfly_twid_o aligns with rd_data. bfly_a_o/bfly_b_o are rd_data passed through.
- Write path: a shift register of depth 1+BFLY_LAT carries {valid, addr_a, addr_b}.
  - Its output drives wr_en_o/wr_addr_*.
  - wr_data_a_o = bfly_a_i, wr_data_b_o = bfly_b_i.
  - A write occurs exactly 1+BFLY_LAT cycles after its read.
- DRAIN: wait until the last write of the stage has been issued.
  - If s < LOG2N-1: s++, k=0, go to ISSUE. The first read of the next stage is in the cycle after the last write.
  - Otherwise go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o = 1 in ISSUE and DRAIN.
- Per-stage period: N/2+1+BFLY_LAT cycles. Total busy cycles: LOG2N*(N/2+1+BFLY_LAT).
- start_i is ignored while not in IDLE, including in the DONE cycle.
- Memory is required to return data written in cycle t on a read in cycle t+1.
- No arithmetic on data; widths pass through unchanged.

Optional Feature:
- Macro FFT_SEQ_INVERSE_EN.
- Defined: adds port inverse_i (in, 1), sampled at start and held for the whole transform. When latched high, the issued angle is (2^ANGLE_BITS - angle) mod 2^ANGLE_BITS, giving a conjugate twiddle for IFFT.
- Undefined: no port; the forward angle is always used.

Decomposition:
- Package fft_pkg: DATA_WIDTH/FRAC_BITS/ANGLE_BITS constants, complex-sample typedef (2×signed DATA_WIDTH), FSM state enum, and an angle-for(s, j) function.
- One sub-module, fft_addr_gen: combinational (s, k) → addr_a, addr_b, angle.

Test Plan (N=16, BFLY_LAT=8; the bench uses an ideal behavioural butterfly with a+Wb / a-Wb and 8-cycle latency, plus a 16-entry memory model):
- Reset held 3 cycles → all outputs 0, busy_o=0; no rd_en_o/wr_en_o while idle.
- start_i pulse at cycle 0 → rd_en_o cycles 1–8, wr_en_o cycles 10–17; stage 1 reads 18–25; last write at cycle 68; done_o=1 at cycle 69 only; busy_o high cycles 1–68.
- Address/twiddle trace: in stage 1, the 4th read (k=3) must show rd_addr_a=5, rd_addr_b=7, and one cycle later bfly_twid_o=0x4000. In stage 0, every angle is 0.
- Impulse: mem[0]=0x4000 re, all else 0 → after done_o, all 16 entries = 0x4000 re, 0 im.
- start_i asserted again at cycle 30 → ignored, same timing. Reset asserted at cycle 30 → cycle 31 all outputs 0, no further writes; a new start completes in 68 busy cycles.
- FFT_SEQ_INVERSE_EN with inverse_i=1: stage 1, k=3 → bfly_twid_o=0xC000; forward impulse test result unchanged.
